// File: rtl/ccg_stim_pkg.sv
// Shared types and constants for the signature-collector harness:
// FSM states, MISR polynomial/seed and the LFSR tap table.
package ccg_stim_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [31:0] MISR_POLY = 32'h04C11DB7;
  localparam logic [31:0] MISR_INIT = 32'hFFFFFFFF;

  // Feedback taps of a maximal-length Fibonacci LFSR, as a bit mask of width n.
  function automatic logic [63:0] lfsr_taps(input int unsigned n);
    logic [63:0] m;
    m = '0;
    case (n)
      8:       begin m[7]  = 1'b1; m[5]  = 1'b1; m[4]  = 1'b1; m[3] = 1'b1; end
      16:      begin m[15] = 1'b1; m[14] = 1'b1; m[12] = 1'b1; m[3] = 1'b1; end
      20:      begin m[19] = 1'b1; m[16] = 1'b1; end
      24:      begin m[23] = 1'b1; m[22] = 1'b1; m[21] = 1'b1; m[16] = 1'b1; end
      32:      begin m[31] = 1'b1; m[21] = 1'b1; m[1]  = 1'b1; m[0] = 1'b1; end
      default: begin m[19] = 1'b1; m[16] = 1'b1; end
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ccg_misr.sv
// 32-bit multiple-input signature register; clear reloads the seed,
// en folds din into the running CRC-32-polynomial signature.
module ccg_misr
  import ccg_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic [31:0] din,
  output logic [31:0] sig
);

  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (clear) begin
      sig_d = MISR_INIT;
    end else if (en) begin
      sig_d = {sig_q[30:0], 1'b0} ^ (sig_q[31] ? MISR_POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= MISR_INIT;
    else        sig_q <= sig_d;
  end

  assign sig = sig_q;

endmodule

// File: rtl/ccg_sig_collector.sv
// Harness stage around a combinational netlist: generates counter/LFSR input
// vectors and compacts the (optionally pipelined) outputs into a MISR signature.
module ccg_sig_collector
  import ccg_stim_pkg::*;
#(
  parameter int unsigned N_IN    = 20,
  parameter int unsigned N_OUT   = 12,
  parameter int unsigned DUT_LAT = 0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            mode,
  input  logic [N_IN-1:0] seed,
  input  logic [N_IN:0]   vec_count,
  output logic [N_IN-1:0] x_o,
  input  logic [N_OUT-1:0] f_i,
  output logic            busy,
  output logic            done,
  output logic [31:0]     signature
);

  localparam logic [N_IN-1:0] TAPS = N_IN'(lfsr_taps(N_IN));
  localparam logic [1:0]      LAT  = 2'(DUT_LAT);

  state_e          state_q;
  logic [N_IN-1:0] x_q;
  logic [N_IN:0]   rem_q;
  logic [1:0]      skip_q;
  logic [1:0]      drain_q;
  logic            mode_q;
  logic            busy_q;
  logic            done_q;

  logic            active;
  logic            accept;
  logic            kill;
  logic            misr_en;
  logic [N_IN-1:0] x_next;
  logic [N_IN-1:0] v0;

  assign active = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign kill   = abort && active;
  assign accept = start && !abort && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  assign v0     = (mode && (seed == '0)) ? N_IN'(1) : seed;
  assign x_next = mode_q ? {x_q[N_IN-2:0], ^(x_q & TAPS)} : x_q + N_IN'(1);

  // The fill counter also gates DRAIN, so a run shorter than the pipeline
  // still absorbs exactly vec_count samples.
  assign misr_en = active && !kill && (skip_q == '0);

  ccg_misr u_misr (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (accept),
    .en    (misr_en),
    .din   (32'(f_i)),
    .sig   (signature)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      x_q     <= '0;
      rem_q   <= '0;
      skip_q  <= '0;
      drain_q <= '0;
      mode_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (kill) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (accept) begin
      mode_q <= mode;
      if (vec_count == '0) begin
        state_q <= ST_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end else begin
        state_q <= ST_RUN;
        x_q     <= v0;
        rem_q   <= vec_count;
        skip_q  <= LAT;
        busy_q  <= 1'b1;
        done_q  <= 1'b0;
      end
    end else begin
      case (state_q)
        ST_RUN: begin
          x_q   <= x_next;
          rem_q <= rem_q - 1'b1;
          if (skip_q != '0) skip_q <= skip_q - 1'b1;
          if (rem_q == (N_IN+1)'(1)) begin
            if (LAT != '0) begin
              state_q <= ST_DRAIN;
              drain_q <= LAT;
            end else begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        ST_DRAIN: begin
          if (skip_q != '0) skip_q <= skip_q - 1'b1;
          drain_q <= drain_q - 1'b1;
          if (drain_q == 2'd1) begin
            state_q <= ST_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_o  = x_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_ccg_sig_collector.sv
// Directed bench: two collectors (DUT_LAT=0 and DUT_LAT=2) share stimulus;
// a netlist stand-in plus reference LFSR/MISR functions give expected values.
module tb_ccg_sig_collector;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, mode, zero_f;
  logic [19:0] seed;
  logic [20:0] vec_count;
  logic [19:0] x0, x2;
  logic [11:0] f0, f2, p1, p2;
  logic        busy0, busy2, done0, done2;
  logic [31:0] sig0, sig2;
  int          total = 0;
  int          bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [11:0] nl(input logic [19:0] x);
    return x[11:0] ^ x[19:8] ^ {x[3:0], x[19:12]};
  endfunction

  function automatic logic [31:0] misr_step(input logic [31:0] s, input logic [11:0] f);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ 32'h04C11DB7;
    return r ^ {20'b0, f};
  endfunction

  function automatic logic [19:0] adv(input logic [19:0] x, input logic m);
    if (m) return {x[18:0], x[19] ^ x[16]};
    return x + 20'd1;
  endfunction

  function automatic logic [31:0] exp_sig(input logic [19:0] s0, input logic m, input int n);
    logic [19:0] v;
    logic [31:0] s;
    v = (m && s0 == 20'd0) ? 20'd1 : s0;
    s = 32'hFFFFFFFF;
    for (int k = 0; k < n; k++) begin
      s = misr_step(s, nl(v));
      v = adv(v, m);
    end
    return s;
  endfunction

  // Two-stage pipelined netlist in front of the DUT_LAT=2 instance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1 <= '0;
      p2 <= '0;
    end else begin
      p1 <= nl(x2);
      p2 <= p1;
    end
  end

  assign f0 = zero_f ? 12'h000 : nl(x0);
  assign f2 = zero_f ? 12'h000 : p2;

  ccg_sig_collector #(.N_IN(20), .N_OUT(12), .DUT_LAT(0)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .vec_count(vec_count), .x_o(x0), .f_i(f0),
    .busy(busy0), .done(done0), .signature(sig0)
  );

  ccg_sig_collector #(.N_IN(20), .N_OUT(12), .DUT_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode),
    .seed(seed), .vec_count(vec_count), .x_o(x2), .f_i(f2),
    .busy(busy2), .done(done2), .signature(sig2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic go(input logic m, input logic [19:0] s, input logic [20:0] n);
    mode = m; seed = s; vec_count = n; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int lim);
    int c;
    c = 0;
    while (!(done0 && done2) && c < lim) begin
      step();
      c++;
    end
    chk("done_within_budget", {62'b0, done0, done2}, 64'd3);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = 1'b0; zero_f = 1'b1;
    seed = '0; vec_count = '0;
    #12;
    chk("rst_x0", x0, 0);
    chk("rst_busy0", busy0, 0);
    chk("rst_done0", done0, 0);
    chk("rst_sig0", sig0, 32'hFFFFFFFF);
    chk("rst_sig2", sig2, 32'hFFFFFFFF);
    step(); rst_n = 1'b1; step();

    // vec_count = 0: straight to DONE
    go(1'b0, 20'h55555, 21'd0);
    chk("zero_done0", done0, 1);
    chk("zero_done2", done2, 1);
    chk("zero_busy0", busy0, 0);
    chk("zero_sig0", sig0, 32'hFFFFFFFF);
    chk("zero_x0", x0, 0);

    // single zero sample
    go(1'b0, 20'h00000, 21'd1);
    chk("one_x0", x0, 0);
    chk("one_busy0", busy0, 1);
    chk("one_done0_early", done0, 0);
    step();
    chk("one_done0", done0, 1);
    chk("one_busy0_fall", busy0, 0);
    chk("one_sig0", sig0, 32'hFB3EE249);
    step(); step();
    chk("one_done2", done2, 1);
    chk("one_sig2", sig2, 32'hFB3EE249);

    // counter wrap
    zero_f = 1'b0;
    go(1'b0, 20'hFFFFF, 21'd2);
    chk("wrap_x0_a", x0, 20'hFFFFF);
    step();
    chk("wrap_x0_b", x0, 20'h00000);
    chk("wrap_busy0", busy0, 1);
    step();
    chk("wrap_done0", done0, 1);
    chk("wrap_sig0", sig0, exp_sig(20'hFFFFF, 1'b0, 2));
    step(); step();
    chk("wrap_done2", done2, 1);
    chk("wrap_sig2", sig2, exp_sig(20'hFFFFF, 1'b0, 2));

    // LFSR, seed 0 replaced by 1; DUT_LAT=2 timing
    go(1'b1, 20'h00000, 21'd3);
    chk("lfsr_x0_0", x0, 20'h00001);
    chk("lfsr_x2_0", x2, 20'h00001);
    step();
    chk("lfsr_x0_1", x0, 20'h00002);
    step();
    chk("lfsr_x0_2", x0, 20'h00004);
    step();
    chk("lfsr_done0_e3", done0, 1);
    chk("lfsr_sig0", sig0, exp_sig(20'h00000, 1'b1, 3));
    chk("lfsr_done2_e3", done2, 0);
    step();
    chk("lfsr_done2_e4", done2, 0);
    chk("lfsr_busy2_e4", busy2, 1);
    step();
    chk("lfsr_done2_e5", done2, 1);
    chk("lfsr_busy2_e5", busy2, 0);
    chk("lfsr_sig2", sig2, exp_sig(20'h00000, 1'b1, 3));

    // abort with simultaneous start, then a clean run
    go(1'b0, 20'h12345, 21'd100);
    repeat (4) step();
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    chk("abort_busy0", busy0, 0);
    chk("abort_done0", done0, 0);
    chk("abort_busy2", busy2, 0);
    chk("abort_done2", done2, 0);
    step();
    chk("abort_idle_busy0", busy0, 0);
    chk("abort_idle_done0", done0, 0);
    go(1'b0, 20'hABCDE, 21'd4);
    run_to_done(20);
    chk("post_abort_sig0", sig0, exp_sig(20'hABCDE, 1'b0, 4));
    chk("post_abort_sig2", sig2, exp_sig(20'hABCDE, 1'b0, 4));

    // start while busy is ignored
    go(1'b1, 20'h0ACE1, 21'd300);
    repeat (10) step();
    mode = 1'b0; seed = 20'h00000; vec_count = 21'd5; start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_ignored", busy0, 1);
    run_to_done(400);
    chk("long_sig0", sig0, exp_sig(20'h0ACE1, 1'b1, 300));
    chk("long_sig2", sig2, exp_sig(20'h0ACE1, 1'b1, 300));

    // asynchronous reset mid-run
    go(1'b0, 20'h00777, 21'd50);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_x0", x0, 0);
    chk("arst_busy0", busy0, 0);
    chk("arst_done0", done0, 0);
    chk("arst_sig0", sig0, 32'hFFFFFFFF);
    chk("arst_x2", x2, 0);
    step(); rst_n = 1'b1; step();
    go(1'b0, 20'hFFFF0, 21'd40);
    run_to_done(60);
    chk("post_rst_sig0", sig0, exp_sig(20'hFFFF0, 1'b0, 40));
    chk("post_rst_sig2", sig2, exp_sig(20'hFFFF0, 1'b0, 40));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ccg_sig_collector.md
# ccg_sig_collector

Sequential harness stage wrapped around one generated combinational benchmark netlist (20 inputs x0..x19, 12 outputs f1..f12). It is upstream of the netlist, driving its input vector, and downstream of it, compacting its output vector. Each vector comes from a counter or an LFSR; each output vector is folded into a 32-bit MISR signature. The resulting signatures label and cross-check BALANCED against original netlist variants in the dataset flow.

## Interface
- N_IN, 20: width of the netlist input vector.
- N_OUT, 12: width of the netlist output vector, N_OUT ≤ 32.
- DUT_LAT, 0: register stages between x_o and f_i, range 0..2.
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- start in 1: one-cycle request to begin a run. Accepted only in IDLE or DONE.
- abort in 1: terminates the current run.
- mode in 1: 0 selects counter, 1 selects LFSR. Sampled with start.
- seed in N_IN: first vector. Sampled with start.
- vec_count in N_IN+1: number of vectors, 0..2^N_IN. Sampled with start.
- x_o out N_IN: registered netlist input vector. Bit i drives xi.
- f_i in N_OUT: netlist outputs. Bit j-1 carries fj.
- busy out 1: high in RUN or DRAIN.
- done out 1: high in DONE.
- signature out 32: MISR value. Held stable in DONE.

## Operation
- States are IDLE, RUN, DRAIN and DONE. Reset state is IDLE.
- Reset values: x_o=0, busy=0, done=0, signature=0xFFFFFFFF.
- start accepted with vec_count>0:
  - signature←0xFFFFFFFF, x_o←v0, remaining←vec_count, skip←DUT_LAT.
  - Next state is RUN.
- start accepted with vec_count=0:
  - signature←0xFFFFFFFF, x_o unchanged.
  - Next state is DONE.
- v0 selection:
  - Counter mode: v0=seed.
  - LFSR mode: v0=seed, except seed=0 is replaced by 1.
- Vector advance, each RUN edge:
  - Counter: x_o←x_o+1 mod 2^N_IN. 0xFFFFF wraps to 0x00000.
  - LFSR: Fibonacci form, left shift. New bit 0 = x_o[19]^x_o[16] (x^20+x^17+1). Taps are a package constant indexed by N_IN.
- MISR update, each edge at which a valid sample is absorbed: sig←{sig[30:0],1'b0} ^ (sig[31]?32'h04C11DB7:0) ^ zero-extended f_i.
- RUN edge behaviour:
  - If skip>0: skip decrements and nothing is absorbed. This covers the pipeline fill.
  - Otherwise f_i is absorbed.
  - remaining decrements on every RUN edge and x_o advances on every RUN edge.
  - When remaining reaches 0: go to DRAIN if DUT_LAT>0, else go to DONE.
- DRAIN: absorbs f_i for exactly DUT_LAT edges, x_o frozen, then go to DONE.
- DONE: holds signature and x_o until the next start.
- Control events:
  - abort in RUN/DRAIN: next state IDLE. Signature is left as-is and is not valid. done stays 0.
  - start and abort in the same cycle: abort wins.
  - start while busy: ignored.
  - rst_n low in any state: immediately forces the reset values.

## Timing
- Start edge E0: x_o=v0 is visible after E0.
- DUT_LAT=0: f_i for vector k is absorbed at edge E0+k+1. done rises after edge E0+vec_count.
- General case: done rises after edge E0+vec_count+DUT_LAT. Exactly vec_count samples are absorbed.
- busy falls in the same edge that done rises.
- Throughput: one vector per cycle, no stalls.

## Structure
- Package ccg_stim_pkg holds:
  - the state enum;
  - MISR_POLY=32'h04C11DB7 and MISR_INIT=32'hFFFFFFFF;
  - an LFSR tap-mask function of N_IN (20 → taps 19,16).
- Sub-module ccg_misr: 32-bit MISR with ports clk, rst_n, clear, en, din[31:0], sig[31:0].
- Vector generator and FSM live in ccg_sig_collector.

## Test plan
- vec_count=0, start → done the next cycle, signature=0xFFFFFFFF, x_o unchanged.
- DUT_LAT=0, mode=0, seed=0, vec_count=1, f_i tied 0 → done after 1 edge, signature=0xFB3EE249.
- mode=0, seed=0xFFFFF, vec_count=2 → x_o sequence 0xFFFFF, 0x00000. Two samples absorbed.
- mode=1, seed=0, vec_count=3 → x_o sequence 0x00001, 0x00002, 0x00004. DUT_LAT=2 → done 5 edges after E0.
- Abort at RUN cycle 5 of vec_count=100 → IDLE next edge, busy=0, done=0. A start in the same cycle is ignored. A new run afterwards completes normally.
- rst_n pulsed low mid-RUN → outputs at reset values asynchronously.
- Full 2^20 counter run on the netlist model → signature equal to the golden model's signature.
